// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with an optional hold limit.
// The owner's bus signals are muxed onto the shared bus with no latency.
`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 29:0
`endif
`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 31:0
`endif
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module bus_arbiter #(
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 M0BusReq_,
    input  logic                 M1BusReq_,
    input  logic                 M2BusReq_,
    input  logic                 M3BusReq_,
    input  logic [`WORD_ADDR_BUS] M0BusAddr,
    input  logic [`WORD_ADDR_BUS] M1BusAddr,
    input  logic [`WORD_ADDR_BUS] M2BusAddr,
    input  logic [`WORD_ADDR_BUS] M3BusAddr,
    input  logic                 M0BusAs_,
    input  logic                 M1BusAs_,
    input  logic                 M2BusAs_,
    input  logic                 M3BusAs_,
    input  logic                 M0BusRW,
    input  logic                 M1BusRW,
    input  logic                 M2BusRW,
    input  logic                 M3BusRW,
    input  logic [`WORD_DATA_BUS] M0BusWrData,
    input  logic [`WORD_DATA_BUS] M1BusWrData,
    input  logic [`WORD_DATA_BUS] M2BusWrData,
    input  logic [`WORD_DATA_BUS] M3BusWrData,
    output logic                 M0BusGrnt_,
    output logic                 M1BusGrnt_,
    output logic                 M2BusGrnt_,
    output logic                 M3BusGrnt_,
    output logic [`WORD_ADDR_BUS] SBusAddr,
    output logic                 SBusAs_,
    output logic                 SBusRW,
    output logic [`WORD_DATA_BUS] SBusWrData,
    output logic [1:0]           Owner
);

    localparam bit               HoldEn  = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] MaxHold = HOLD_W'(MAX_HOLD);

    logic [3:0]        req_;
    logic [3:0]        as_;
    logic [1:0]        owner;
    logic [1:0]        nextOwner;
    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] nextHoldCnt;
    logic [1:0]        rrOwner;
    logic              rrFound;
    logic              ownerReq;
    logic              ownerBusy;
    logic              othersWait;
    logic [3:0]        grnt_;

    assign req_ = {M3BusReq_, M2BusReq_, M1BusReq_, M0BusReq_};
    assign as_  = {M3BusAs_, M2BusAs_, M1BusAs_, M0BusAs_};

    assign ownerReq   = ~req_[owner];
    assign ownerBusy  = ~as_[owner];
    assign othersWait = |(~req_ & ~(4'b0001 << owner));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner   <= 2'd0;
            holdCnt <= '0;
        end else begin
            owner   <= nextOwner;
            holdCnt <= nextHoldCnt;
        end
    end

    // Closest requester after the owner wins, so scan from farthest to nearest.
    always_comb begin
        rrFound = 1'b0;
        rrOwner = owner;
        for (int i = 3; i >= 1; i--) begin
            if (!req_[owner + 2'(i)]) begin
                rrFound = 1'b1;
                rrOwner = owner + 2'(i);
            end
        end
    end

    always_comb begin
        nextOwner = owner;
        if (!ownerBusy) begin
            if (!ownerReq) begin
                if (rrFound) nextOwner = rrOwner;
            end else if (HoldEn && (holdCnt == MaxHold) && rrFound) begin
                nextOwner = rrOwner;
            end
        end
    end

    // Counter parks at the limit while a busy owner defers the handover.
    always_comb begin
        nextHoldCnt = holdCnt;
        if ((nextOwner != owner) || !ownerReq || !othersWait) begin
            nextHoldCnt = '0;
        end else if (HoldEn ? (holdCnt < MaxHold) : (holdCnt != '1)) begin
            nextHoldCnt = holdCnt + 1'b1;
        end
    end

    always_comb begin
        grnt_ = ~(4'b0001 << owner);
        case (owner)
            2'd0: begin
                SBusAddr = M0BusAddr; SBusAs_ = M0BusAs_;
                SBusRW = M0BusRW; SBusWrData = M0BusWrData;
            end
            2'd1: begin
                SBusAddr = M1BusAddr; SBusAs_ = M1BusAs_;
                SBusRW = M1BusRW; SBusWrData = M1BusWrData;
            end
            2'd2: begin
                SBusAddr = M2BusAddr; SBusAs_ = M2BusAs_;
                SBusRW = M2BusRW; SBusWrData = M2BusWrData;
            end
            default: begin
                SBusAddr = M3BusAddr; SBusAs_ = M3BusAs_;
                SBusRW = M3BusRW; SBusWrData = M3BusWrData;
            end
        endcase
    end

    assign M0BusGrnt_ = grnt_[0];
    assign M1BusGrnt_ = grnt_[1];
    assign M2BusGrnt_ = grnt_[2];
    assign M3BusGrnt_ = grnt_[3];
    assign Owner      = owner;

endmodule
